// File: rtl/uart_tx_device.sv
// uart_tx_device: memory-mapped UART transmitter (8N1) with a transmit FIFO on the shared data bus.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1 framing).

module uart_tx_device #(
    parameter int unsigned           DBITS        = 32,
    parameter logic [DBITS-1:0]      TX_ADDR      = 32'hF000_0030,
    parameter logic [DBITS-1:0]      TXCTRL_ADDR  = 32'hF000_0130,
    parameter int unsigned           CLKS_PER_BIT = 434,
    parameter int unsigned           FIFO_DEPTH   = 8
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [DBITS-1:0] dbus,
    input  logic [DBITS-1:0] address,
    input  logic             wrtEn,
    output logic             tx
);

    localparam int unsigned       BAUD_W      = $clog2(CLKS_PER_BIT);
    localparam int unsigned       PTR_W       = $clog2(FIFO_DEPTH);
    localparam int unsigned       CNT_W       = PTR_W + 1;
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
    localparam logic              PARITY_FLAG = 1'b1;
`else
    localparam logic              PARITY_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_q, par_d;
    logic                tx_q, tx_d;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;

    logic                wr_tx_s, wr_ctrl_s, push_ok_s, pop_s, load_s;
    logic                flush_s, ovf_clr_s, full_s, empty_s, busy_s, tick_s, rd_hit_s;
    logic [7:0]          head_s;
    logic [15:0]         status_s;
    logic [DBITS-1:0]    rdata_s;
    logic                unused_s;

    assign wr_tx_s   = wrtEn & (address == TX_ADDR);
    assign wr_ctrl_s = wrtEn & (address == TXCTRL_ADDR);
    assign flush_s   = wr_ctrl_s & dbus[4];
    assign ovf_clr_s = wr_ctrl_s & dbus[3];
    assign full_s    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_s   = (count_q == CNT_W'(0));
    assign push_ok_s = wr_tx_s & ~full_s;
    assign pop_s     = load_s;
    assign head_s    = mem_q[rd_ptr_q];
    assign busy_s    = (state_q != S_IDLE);
    assign tick_s    = (baud_q == BAUD_W'(0));
    assign unused_s  = ^dbus[DBITS-1:8];

    // FIFO pointer / occupancy next-state; flush discards everything queued
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Overflow flag: a push that finds the FIFO full is dropped and remembered
    always_comb begin
        if (wr_tx_s && full_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO storage, pointers, count and overflow registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= dbus[7:0];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FSM state register plus serialiser datapath and registered tx
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= BAUD_W'(0);
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // FSM next-state: one bit period per baud-counter wrap; STOP chains straight into START
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        load_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_s) begin
                    load_s = 1'b1;
                end else begin
                    baud_d = BAUD_W'(0);
                end
            end
            S_START: begin
                if (tick_s) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    baud_d  = BAUD_RELOAD;
                end else begin
                    baud_d  = baud_q - BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (tick_s) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick_s) begin
                    state_d = S_STOP;
                    baud_d  = BAUD_RELOAD;
                end else begin
                    baud_d  = baud_q - BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (tick_s) begin
                    if (!empty_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        baud_d  = BAUD_W'(0);
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = BAUD_W'(0);
            end
        endcase
        if (load_s) begin
            state_d = S_START;
            shift_d = head_s;
            par_d   = ^head_s;
            bit_d   = 3'd0;
            baud_d  = BAUD_RELOAD;
        end else begin
            par_d   = par_d;
        end
    end

    // FSM output: tx is computed from the next state so the line changes right after the transition edge
    always_comb begin
        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx = tx_q;

    assign status_s = {8'(count_q), 3'b000, PARITY_FLAG, ovf_q, empty_s, full_s, busy_s};
    assign rd_hit_s = ~wrtEn & ((address == TXCTRL_ADDR) | (address == TX_ADDR));

    // Read data: status register at TXCTRL_ADDR, zero at TX_ADDR
    always_comb begin
        if (address == TXCTRL_ADDR) begin
            rdata_s = {{(DBITS-16){1'b0}}, status_s};
        end else begin
            rdata_s = {DBITS{1'b0}};
        end
    end

    assign dbus = rd_hit_s ? rdata_s : {DBITS{1'bz}};

endmodule

// File: tb/tb_uart_tx_device.sv
// tb_uart_tx_device: register-table checks, framed-stream checks against an arithmetic frame model,
// randomized bursts, overflow, flush and mid-frame reset sequences.

module tb_uart_tx_device;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS = 11;
    localparam logic [31:0] PF    = 32'h0000_0010;
`else
    localparam int          NBITS = 10;
    localparam logic [31:0] PF    = 32'h0000_0000;
`endif
    localparam int          FRAME = NBITS * CPB;
    localparam logic [31:0] TXA   = 32'hF000_0030;
    localparam logic [31:0] CTA   = 32'hF000_0130;
    localparam logic [31:0] NOA   = 32'hF000_0014;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        wrtEn    = 1'b0;
    logic [31:0] address  = NOA;
    logic [31:0] drv_data = 32'h0;
    logic        drv_en   = 1'b0;
    wire  [31:0] dbus;
    logic        tx;

    assign dbus = drv_en ? drv_data : 32'bz;

    for (genvar gi = 0; gi < 32; gi++) begin : g_pu
        pullup pu (dbus[gi]);
    end

    uart_tx_device #(
        .DBITS(32), .TX_ADDR(TXA), .TXCTRL_ADDR(CTA),
        .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .dbus(dbus),
        .address(address), .wrtEn(wrtEn), .tx(tx)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    typedef struct {
        logic        do_wr;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] ra;
        logic [31:0] exp;
    } vec_t;

    op_t        ops[$];
    logic [7:0] exp_q[$];
    vec_t       tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Serial line level at a given cycle offset inside a frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int off);
        int idx;
        idx = off / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (NBITS == 11 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic wr_cycle(input logic [31:0] a, input logic [31:0] d);
        drv_en = 1'b1; wrtEn = 1'b1; address = a; drv_data = d;
        @(posedge clk); #1;
        drv_en = 1'b0; wrtEn = 1'b0; address = NOA;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        drv_en = 1'b0; wrtEn = 1'b0; address = a;
        #1;
        d = dbus;
    endtask

    // Apply ops one per cycle, then idle-read status; check tx and busy every cycle
    task automatic run_stream(input int extra);
        int n, total, t;
        logic e;
        n     = exp_q.size();
        total = ops.size() + n * FRAME + extra;
        for (int c = 0; c < total; c++) begin
            if (c < ops.size()) begin
                drv_en = 1'b1; wrtEn = 1'b1; address = ops[c].addr; drv_data = ops[c].data;
            end else begin
                drv_en = 1'b0; wrtEn = 1'b0; address = CTA;
            end
            @(posedge clk); #1;
            if (c >= 1) begin
                t = c - 1;
                e = (t < n * FRAME) ? frame_bit(exp_q[t / FRAME], t % FRAME) : 1'b1;
                check("tx_stream", 32'(tx), 32'(e));
                if (c >= ops.size()) begin
                    check("busy_stream", 32'(dbus[0]), 32'(t < n * FRAME));
                end
            end
        end
        drv_en = 1'b0; wrtEn = 1'b0; address = NOA;
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        int          n, waited;

        tbl[0] = '{1'b0, NOA, 32'h0,  NOA,          32'hFFFF_FFFF};
        tbl[1] = '{1'b0, NOA, 32'h0,  TXA,          32'h0000_0000};
        tbl[2] = '{1'b0, NOA, 32'h0,  CTA,          32'h0000_0004 | PF};
        tbl[3] = '{1'b1, CTA, 32'h8,  CTA,          32'h0000_0004 | PF};
        tbl[4] = '{1'b1, NOA, 32'hAB, CTA,          32'h0000_0004 | PF};
        tbl[5] = '{1'b1, CTA, 32'h10, CTA,          32'h0000_0004 | PF};
        tbl[6] = '{1'b1, 32'hF000_0031, 32'h5A, CTA, 32'h0000_0004 | PF};
        tbl[7] = '{1'b0, NOA, 32'h0,  32'h0000_0030, 32'hFFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        check("tx_in_reset", 32'(tx), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("tx_after_reset", 32'(tx), 32'h1);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].do_wr) wr_cycle(tbl[i].wa, tbl[i].wd);
            rd(tbl[i].ra, r);
            check($sformatf("table[%0d]", i), r, tbl[i].exp);
            @(posedge clk); #1;
            check($sformatf("table_tx[%0d]", i), 32'(tx), 32'h1);
        end

        // Single byte 8'hA5
        ops = {}; exp_q = {};
        ops.push_back('{TXA, 32'hA5}); exp_q.push_back(8'hA5);
        run_stream(4);
        rd(CTA, r); check("status_after_a5", r, 32'h4 | PF);

        // Three contiguous frames
        ops = {}; exp_q = {};
        for (int i = 1; i <= 3; i++) begin
            ops.push_back('{TXA, 32'(i)}); exp_q.push_back(8'(i));
        end
        run_stream(4);

        // Parity-sensitive byte
        ops = {}; exp_q = {};
        ops.push_back('{TXA, 32'h07}); exp_q.push_back(8'h07);
        run_stream(3);

        // Randomized bursts
        for (int k = 0; k < 6; k++) begin
            ops = {}; exp_q = {};
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                ops.push_back('{TXA, {$urandom_range(0, 255) << 8, b}});
                exp_q.push_back(b);
            end
            run_stream(2);
        end

        // Overflow: 9 writes fill the FIFO (one already popped), the 10th overflows
        for (int i = 0; i < 9; i++) wr_cycle(TXA, 32'(8'h30 + i));
        rd(CTA, r); check("status_full", r, 32'h0000_0803 | PF);
        wr_cycle(TXA, 32'h99);
        rd(CTA, r); check("status_overflow", r, 32'h0000_080B | PF);
        wr_cycle(CTA, 32'h8);
        rd(CTA, r); check("status_ovf_clear", r, 32'h0000_0803 | PF);
        wr_cycle(CTA, 32'h10);
        rd(CTA, r); check("status_flushed", r, 32'h0000_0005 | PF);
        waited = 0;
        while (r[0] && waited < 2 * FRAME) begin
            @(posedge clk); #1;
            rd(CTA, r);
            waited++;
        end
        check("idle_after_flush", 32'(r[0]), 32'h0);
        check("status_idle", r, 32'h0000_0004 | PF);

        // Flush during the first of four queued frames
        ops = {}; exp_q = {};
        for (int i = 0; i < 4; i++) ops.push_back('{TXA, 32'(8'hC0 + i)});
        ops.push_back('{CTA, 32'h10});
        exp_q.push_back(8'hC0);
        run_stream(8);
        rd(CTA, r); check("status_after_flush_seq", r, 32'h4 | PF);

        // Reset mid-frame on an all-zero byte so tx is low when reset hits
        wr_cycle(TXA, 32'h00);
        repeat (6) @(posedge clk);
        #1;
        check("tx_low_before_reset", 32'(tx), 32'h0);
        #2 reset = 1'b0;
        #1;
        check("tx_async_reset", 32'(tx), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        rd(CTA, r); check("status_post_reset", r, 32'h4 | PF);
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk); #1;
            check("tx_quiet_post_reset", 32'(tx), 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_device.md
Name: uart_tx_device

Overview:
- Memory-mapped UART transmitter that sits on the processor's shared data bus (dbus/address/wrtEn) beside the timer, key, switch, HEX and LED controllers.
- Acts as a bus responder: the processor writes bytes into a transmit FIFO and polls a control/status register.
- Serialises queued bytes as 8N1 frames on a single tx pin at a fixed baud set by a clock divider.

Parameters:
- DBITS, 32, data bus and address width.
- TX_ADDR, 32'hF000_0030, data register address; write pushes a byte.
- TXCTRL_ADDR, 32'hF000_0130, control/status register address.
- CLKS_PER_BIT, 434, clk cycles per serial bit; minimum 2.
- FIFO_DEPTH, 8, transmit FIFO entries; power of 2, range 2..128.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- dbus  inout  DBITS  shared data bus; driven only during a matching read, otherwise high-Z.
- address  input  DBITS  bus address.
- wrtEn  input  1  bus write strobe; high = write, low = read.
- tx  output  1  serial output; idles high.

Behaviour:
- Reset (asserted low, async): FIFO empty, count 0, overflow 0, state IDLE, baud/bit counters 0, tx=1, dbus high-Z. Takes effect immediately, including mid-frame; tx returns high with no stop bit.
- Bus write: sampled on posedge clk when wrtEn=1 and address matches.
  - TX_ADDR: push dbus[7:0]. If FIFO full (occupancy before any same-cycle pop), the byte is dropped and overflow is set.
  - TXCTRL_ADDR: dbus[3]=1 clears overflow. dbus[4]=1 flushes the FIFO (count→0); a frame already in progress completes. Flush and push in the same cycle cannot occur (different addresses).
- Bus read (wrtEn=0), combinational:
  - TXCTRL_ADDR: dbus = {16'b0, count[7:0], 4'b0, overflow, empty, full, busy}; busy = state≠IDLE.
  - TX_ADDR: dbus = 0.
  - Any other address: high-Z.
- FIFO: circular buffer with read/write pointers and a count. Simultaneous push and pop when not full keeps count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty, pop head into the shift register, load baud counter with CLKS_PER_BIT-1, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first; each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency: a byte written at edge N into an empty FIFO while IDLE is popped at edge N+1; tx falls after edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles; back-to-back frames are contiguous.
- Baud counter: counts down and reloads at 0; no drift across frames.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT.
  - Status bit 4 reads 1.
- Undefined:
  - No PARITY state; 8N1 framing as above.
  - Status bit 4 reads 0.

Test Plan:
- Reset with reset=0 mid-frame (CLKS_PER_BIT=4) → tx=1 immediately; status read after release = 32'h0000_0004 (empty only).
- Write 8'hA5 to TX_ADDR while IDLE, CLKS_PER_BIT=4 → tx low from edge N+1 for 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then stop high 4 cycles; busy=1 throughout, 0 after.
- Write 3 bytes 8'h01, 8'h02, 8'h03 back-to-back → three contiguous frames, 120 cycles total at CLKS_PER_BIT=4; no idle cycle between stop and next start.
- Hold tx off by writing FIFO_DEPTH+1=9 bytes quickly with FIFO_DEPTH=8 → first byte popped, 8 queued, full=1; 10th write sets overflow=1; write 32'h8 to TXCTRL_ADDR → overflow=0.
- Queue 4 bytes, then write 32'h10 to TXCTRL_ADDR during the first frame → current frame completes, count=0, empty=1, no further frames.
- Read address 32'hF000_0014 → dbus high-Z from this block; read TX_ADDR → 32'h0. With UART_TX_PARITY_EN, sending 8'h07 → parity bit 1, frame 44 cycles at CLKS_PER_BIT=4.
